// File: rtl/csa_accumulate_matcher.sv
// ---------------------------------------------------------------------------
// csa_accumulate_matcher
//
// Streaming accumulator whose running sum lives in carry-save form (a sum
// vector and a carry vector). Every accepted delta is folded in with a single
// 3:2 compressor layer, and the "does the new sum equal the target" question
// is answered with the carry-free (X+Y)==T identity. As a result, neither the
// update path nor the compare path contains a carry chain. A resolved copy of
// the sum is kept one cycle behind for observation.
// ---------------------------------------------------------------------------
module csa_accumulate_matcher #(
    parameter int WIDTH = 32,
    parameter int SEQ_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_load,
    input  logic [WIDTH-1:0] cfg_init,
    input  logic [WIDTH-1:0] cfg_target,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_delta,
    output logic             hit_valid,
    input  logic             hit_ready,
    output logic [SEQ_W-1:0] hit_seq,
    output logic [WIDTH-1:0] acc_value,
    output logic             running
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q;
    logic             running_q;
    logic [WIDTH-1:0] accSum_q;
    logic [WIDTH-1:0] accCarry_q;
    logic [WIDTH-1:0] target_q;
    logic [WIDTH-1:0] accValue_q;
    logic [SEQ_W-1:0] seq_q;
    logic [SEQ_W-1:0] hitSeq_q;
    logic             hitValid_q;

    logic             readyNow;
    logic             acceptNow;
    logic [WIDTH-1:0] sumNext_d;
    logic [WIDTH-1:0] carryNext_d;
    logic [SEQ_W-1:0] seqNext_d;
    logic [WIDTH-1:0] targetInv;
    logic [WIDTH-1:0] zVec;
    logic [WIDTH-1:0] kVec;
    logic             matchNow;

    // Handshake: a new delta may only enter while running and not loading,
    // and only when the hit slot is free or is being emptied in this cycle.
    // This is what guarantees that a pending hit is never overwritten.
    always_comb begin
        readyNow  = running_q & ~cfg_load & (~hitValid_q | hit_ready);
        acceptNow = in_valid & readyNow;
    end

    // One 3:2 compressor layer folds the delta into the carry-save pair.
    // The carry out of the MSB is dropped, which gives mod-2^WIDTH arithmetic.
    always_comb begin
        sumNext_d   = accSum_q ^ accCarry_q ^ in_delta;
        carryNext_d = {(accSum_q[WIDTH-2:0] & accCarry_q[WIDTH-2:0]) |
                       (accSum_q[WIDTH-2:0] & in_delta[WIDTH-2:0])   |
                       (accCarry_q[WIDTH-2:0] & in_delta[WIDTH-2:0]),
                       1'b0};
        seqNext_d   = seq_q + {{(SEQ_W-1){1'b0}}, 1'b1};
    end

    // Carry-free equality test. s+c == t holds exactly when s + c + ~t is all
    // ones. Compressing (s, c, ~t) into z plus a shifted carry k, that
    // all-ones condition reduces to z ^ k being all ones. No carry ripples.
    always_comb begin
        targetInv = ~target_q;
        zVec      = sumNext_d ^ carryNext_d ^ targetInv;
        kVec      = {(sumNext_d[WIDTH-2:0] & carryNext_d[WIDTH-2:0]) |
                     ((sumNext_d[WIDTH-2:0] | carryNext_d[WIDTH-2:0]) &
                      targetInv[WIDTH-2:0]),
                     1'b0};
        matchNow  = &(zVec ^ kVec);
    end

    // Control FSM and all datapath state in one register block. A load
    // (allowed in any state) reseeds the accumulator and drops any pending
    // hit. Otherwise, an accepted delta advances the sum and the sequence
    // number, and the hit slot is either refilled by a match or emptied by
    // the consumer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            running_q  <= 1'b0;
            accSum_q   <= '0;
            accCarry_q <= '0;
            target_q   <= '0;
            accValue_q <= '0;
            seq_q      <= '0;
            hitSeq_q   <= '0;
            hitValid_q <= 1'b0;
        end else begin
            accValue_q <= accSum_q + accCarry_q;
            if (cfg_load) begin
                state_q    <= RUN;
                running_q  <= 1'b1;
                accSum_q   <= cfg_init;
                accCarry_q <= '0;
                target_q   <= cfg_target;
                seq_q      <= '0;
                hitValid_q <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        running_q <= 1'b0;
                    end
                    RUN: begin
                        running_q <= 1'b1;
                        if (acceptNow) begin
                            accSum_q   <= sumNext_d;
                            accCarry_q <= carryNext_d;
                            seq_q      <= seqNext_d;
                        end
                        if (acceptNow && matchNow) begin
                            hitValid_q <= 1'b1;
                            hitSeq_q   <= seqNext_d;
                        end else if (hit_ready) begin
                            hitValid_q <= 1'b0;
                        end
                    end
                    default: begin
                        state_q   <= IDLE;
                        running_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Outputs come straight from registers, except in_ready, which is the
    // combinational handshake term.
    always_comb begin
        in_ready  = readyNow;
        hit_valid = hitValid_q;
        hit_seq   = hitSeq_q;
        acc_value = accValue_q;
        running   = running_q;
    end

endmodule

// File: tb/tb_csa_accumulate_matcher.sv
// ---------------------------------------------------------------------------
// Testbench for csa_accumulate_matcher (8-bit accumulator, 4-bit sequence so
// that both value wrap and sequence wrap are cheap to reach). A plain
// arithmetic reference model tracks the resolved sum and hit slot; a compare
// process checks the DUT against it every cycle, and directed scenarios add
// hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_csa_accumulate_matcher;

    localparam int W  = 8;
    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cfg_load = 1'b0;
    logic [W-1:0]  cfg_init = '0;
    logic [W-1:0]  cfg_target = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_delta = '0;
    logic          hit_valid;
    logic          hit_ready = 1'b0;
    logic [SW-1:0] hit_seq;
    logic [W-1:0]  acc_value;
    logic          running;

    int checkCount = 0;
    int passCount  = 0;
    int hitEvents  = 0;
    bit compareOn  = 1'b0;

    logic [W-1:0]  mSum = '0;
    logic [W-1:0]  mTarget = '0;
    logic [W-1:0]  mAccValue = '0;
    logic [SW-1:0] mSeq = '0;
    logic [SW-1:0] mHitSeq = '0;
    logic          mHitValid = 1'b0;
    logic          mRunning = 1'b0;
    logic          mReady;

    csa_accumulate_matcher #(.WIDTH(W), .SEQ_W(SW)) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_load   (cfg_load),
        .cfg_init   (cfg_init),
        .cfg_target (cfg_target),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_delta   (in_delta),
        .hit_valid  (hit_valid),
        .hit_ready  (hit_ready),
        .hit_seq    (hit_seq),
        .acc_value  (acc_value),
        .running    (running)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    // Reference model: the accumulator is just a wrapping 8-bit sum, a hit is
    // "sum equals target right after an accepted delta", and acc_value is the
    // sum as it stood one edge earlier.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mSum      = '0;
            mTarget   = '0;
            mAccValue = '0;
            mSeq      = '0;
            mHitSeq   = '0;
            mHitValid = 1'b0;
            mRunning  = 1'b0;
        end else begin
            mAccValue = mSum;
            mReady    = mRunning && !cfg_load && (!mHitValid || hit_ready);
            if (cfg_load) begin
                mSum      = cfg_init;
                mTarget   = cfg_target;
                mSeq      = '0;
                mHitValid = 1'b0;
                mRunning  = 1'b1;
            end else if (in_valid && mReady) begin
                mSum = mSum + in_delta;
                mSeq = mSeq + 1'b1;
                if (mSum == mTarget) begin
                    mHitValid = 1'b1;
                    mHitSeq   = mSeq;
                    hitEvents++;
                end else begin
                    mHitValid = 1'b0;
                end
            end else if (hit_ready) begin
                mHitValid = 1'b0;
            end
        end
    end

    // Compare every output against the model on the falling edge, where the
    // inputs and registered outputs are both settled.
    always @(negedge clk) begin
        if (compareOn && !rst) begin
            checkOutput("running", 32'(running), 32'(mRunning));
            checkOutput("in_ready", 32'(in_ready),
                        32'(mRunning && !cfg_load && (!mHitValid || hit_ready)));
            checkOutput("hit_valid", 32'(hit_valid), 32'(mHitValid));
            if (mHitValid)
                checkOutput("hit_seq", 32'(hit_seq), 32'(mHitSeq));
            checkOutput("acc_value", 32'(acc_value), 32'(mAccValue));
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual === expected)
            passCount++;
        else
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     name, actual, expected, $time);
    endtask

    task automatic driveInputs(input logic ld, input logic [W-1:0] init,
                               input logic [W-1:0] tgt, input logic vld,
                               input logic [W-1:0] dlt, input logic hr);
        cfg_load   = ld;
        cfg_init   = init;
        cfg_target = tgt;
        in_valid   = vld;
        in_delta   = dlt;
        hit_ready  = hr;
    endtask

    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic ld, input logic [W-1:0] init,
                                 input logic [W-1:0] tgt, input logic vld,
                                 input logic [W-1:0] dlt, input logic hr);
        driveInputs(ld, init, tgt, vld, dlt, hr);
        stepClock();
    endtask

    initial begin
        logic [W-1:0] d;
        logic         ld, vld, hr;

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        compareOn = 1'b1;
        $display("[TB] reset state");
        checkOutput("rst_hit_valid", 32'(hit_valid), 32'd0);
        checkOutput("rst_running", 32'(running), 32'd0);
        checkOutput("rst_acc_value", 32'(acc_value), 32'd0);
        checkOutput("rst_hit_seq", 32'(hit_seq), 32'd0);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd0);

        $display("[TB] init 0 target 10, deltas 3,3,4");
        applyStimulus(1'b1, 8'd0, 8'd10, 1'b0, 8'd0, 1'b1);
        checkOutput("t1_running", 32'(running), 32'd1);
        applyStimulus(1'b0, 8'd0, 8'd0, 1'b1, 8'd3, 1'b1);
        applyStimulus(1'b0, 8'd0, 8'd0, 1'b1, 8'd3, 1'b1);
        checkOutput("t1_no_early_hit", 32'(hit_valid), 32'd0);
        applyStimulus(1'b0, 8'd0, 8'd0, 1'b1, 8'd4, 1'b1);
        checkOutput("t1_hit_valid", 32'(hit_valid), 32'd1);
        checkOutput("t1_hit_seq", 32'(hit_seq), 32'd3);
        applyStimulus(1'b0, 8'd0, 8'd0, 1'b0, 8'd0, 1'b1);
        checkOutput("t1_single_pulse", 32'(hit_valid), 32'd0);
        checkOutput("t1_acc_value", 32'(acc_value), 32'd10);

        $display("[TB] wrap: init 0xF0 target 0x05 delta 0x15");
        applyStimulus(1'b1, 8'hF0, 8'h05, 1'b0, 8'd0, 1'b1);
        applyStimulus(1'b0, 8'd0, 8'd0, 1'b1, 8'h15, 1'b1);
        checkOutput("t2_hit_valid", 32'(hit_valid), 32'd1);
        checkOutput("t2_hit_seq", 32'(hit_seq), 32'd1);

        $display("[TB] backpressure on pending hit");
        for (int i = 0; i < 5; i++) begin
            driveInputs(1'b0, 8'd0, 8'd0, 1'b1, 8'd2, 1'b0);
            #1 checkOutput("t3_in_ready_low", 32'(in_ready), 32'd0);
            stepClock();
            checkOutput("t3_hit_held", 32'(hit_valid), 32'd1);
            checkOutput("t3_hit_seq_stable", 32'(hit_seq), 32'd1);
            if (i == 0)
                checkOutput("t2_acc_value", 32'(acc_value), 32'h05);
        end
        driveInputs(1'b0, 8'd0, 8'd0, 1'b1, 8'd0, 1'b1);
        #1 checkOutput("t3_in_ready_release", 32'(in_ready), 32'd1);
        stepClock();
        checkOutput("t4_zero_hit1", 32'(hit_valid), 32'd1);
        checkOutput("t4_zero_seq1", 32'(hit_seq), 32'd2);
        applyStimulus(1'b0, 8'd0, 8'd0, 1'b1, 8'd0, 1'b1);
        checkOutput("t4_zero_hit2", 32'(hit_valid), 32'd1);
        checkOutput("t4_zero_seq2", 32'(hit_seq), 32'd3);

        $display("[TB] reload while hit pending");
        driveInputs(1'b1, 8'h10, 8'h20, 1'b1, 8'h55, 1'b0);
        #1 checkOutput("t5_in_ready_load", 32'(in_ready), 32'd0);
        stepClock();
        checkOutput("t5_hit_dropped", 32'(hit_valid), 32'd0);
        applyStimulus(1'b0, 8'd0, 8'd0, 1'b1, 8'h10, 1'b1);
        checkOutput("t5_hit_valid", 32'(hit_valid), 32'd1);
        checkOutput("t5_seq_restart", 32'(hit_seq), 32'd1);

        $display("[TB] load with init == target, then sequence wrap");
        applyStimulus(1'b1, 8'd0, 8'd0, 1'b0, 8'd0, 1'b1);
        checkOutput("t7_load_no_hit", 32'(hit_valid), 32'd0);
        for (int i = 0; i < 16; i++)
            applyStimulus(1'b0, 8'd0, 8'd0, 1'b1, 8'h10, 1'b1);
        checkOutput("t7_wrap_hit", 32'(hit_valid), 32'd1);
        checkOutput("t7_wrap_seq", 32'(hit_seq), 32'd0);

        $display("[TB] random traffic");
        for (int i = 0; i < 3000; i++) begin
            ld  = ($urandom_range(0, 199) == 0);
            vld = ($urandom_range(0, 3) != 0);
            hr  = ($urandom_range(0, 2) != 0);
            case ($urandom_range(0, 3))
                0:       d = mTarget - mSum;
                1:       d = '0;
                default: d = W'($urandom);
            endcase
            applyStimulus(ld, W'($urandom), W'($urandom_range(0, 15)), vld, d, hr);
        end

        $display("[TB] asynchronous reset mid-operation");
        applyStimulus(1'b1, 8'd7, 8'd9, 1'b0, 8'd0, 1'b0);
        applyStimulus(1'b0, 8'd0, 8'd0, 1'b1, 8'd2, 1'b0);
        #2 rst = 1'b1;
        #1;
        checkOutput("ar_hit_valid", 32'(hit_valid), 32'd0);
        checkOutput("ar_running", 32'(running), 32'd0);
        checkOutput("ar_acc_value", 32'(acc_value), 32'd0);
        checkOutput("ar_in_ready", 32'(in_ready), 32'd0);
        driveInputs(1'b0, 8'd0, 8'd0, 1'b0, 8'd0, 1'b0);
        stepClock();
        rst = 1'b0;
        applyStimulus(1'b1, 8'd1, 8'd4, 1'b0, 8'd0, 1'b1);
        applyStimulus(1'b0, 8'd0, 8'd0, 1'b1, 8'd3, 1'b1);
        checkOutput("ar_reload_hit", 32'(hit_valid), 32'd1);
        checkOutput("ar_reload_seq", 32'(hit_seq), 32'd1);
        applyStimulus(1'b0, 8'd0, 8'd0, 1'b0, 8'd0, 1'b1);

        compareOn = 1'b0;
        $display("[TB] model hit events: %0d", hitEvents);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
